// File: rtl/instruction_fetch_controller_if.sv
// Handshake and memory bus between the fetch controller and its surroundings.
// The master modport is the controller side; the slave modport is memory, execute and decode.
interface instruction_fetch_controller_if;
  logic        start;
  logic        mem_load;
  logic [63:0] mem_addr;
  logic [63:0] mem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_instruction;
  logic [63:0] out_pc;
  logic        busy;
  logic        halted;

  modport master (
    input  start, mem_instruction, redirect_valid, redirect_target, out_ready,
    output mem_load, mem_addr, out_valid, out_instruction, out_pc, busy, halted
  );

  modport slave (
    output start, mem_instruction, redirect_valid, redirect_target, out_ready,
    input  mem_load, mem_addr, out_valid, out_instruction, out_pc, busy, halted
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: loads program memory, then streams 64-bit words to decode
// through a valid/ready slot, honouring branch redirects and halting outside the program.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_LOAD | load strobe issued, waiting LOAD_WAIT cycles for memory to fill
// S_RUN  | fetching one word per cycle into the output slot
// S_HALT | PC left the program; held output drains, start/redirect resume
module instruction_fetch_controller #(
  parameter int unsigned NUM_INSTRUCTIONS = 15,
  parameter int unsigned LOAD_WAIT        = 4,
  parameter logic [63:0] RESET_PC         = 64'd0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  instruction_fetch_controller_if.master      fc
);

  localparam int unsigned CNT_W     = $clog2(LOAD_WAIT + 1);
  localparam logic [63:0] NUM_WORDS = 64'(NUM_INSTRUCTIONS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q;
  logic [63:0]        pc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mem_load_q;
  logic               out_valid_q;
  logic [63:0]        out_instruction_q;
  logic [63:0]        out_pc_q;
  logic               busy_q;
  logic               halted_q;

  logic [63:0]        redir_pc;
  logic               redir_in_range;
  logic               pc_in_range;
  logic               slot_free;

  assign redir_pc       = fc.redirect_target & ~64'h7;
  assign redir_in_range = (fc.redirect_target >> 3) < NUM_WORDS;
  assign pc_in_range    = (pc_q >> 3) < NUM_WORDS;
  assign slot_free      = !out_valid_q || fc.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      pc_q              <= RESET_PC;
      cnt_q             <= '0;
      mem_load_q        <= 1'b0;
      out_valid_q       <= 1'b0;
      out_instruction_q <= 64'd0;
      out_pc_q          <= 64'd0;
      busy_q            <= 1'b0;
      halted_q          <= 1'b0;
    end else begin
      mem_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fc.start) begin
            state_q     <= S_LOAD;
            pc_q        <= RESET_PC;
            cnt_q       <= CNT_W'(LOAD_WAIT);
            mem_load_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
          end
        end

        S_LOAD: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (fc.redirect_valid) begin
            // The redirect flushes the slot even if decode is accepting it this cycle.
            pc_q        <= redir_pc;
            out_valid_q <= 1'b0;
            if (!redir_in_range) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
          end else if (!pc_in_range) begin
            state_q     <= S_HALT;
            busy_q      <= 1'b0;
            halted_q    <= 1'b1;
            out_valid_q <= out_valid_q && !fc.out_ready;
          end else if (slot_free) begin
            out_instruction_q <= fc.mem_instruction;
            out_pc_q          <= pc_q;
            out_valid_q       <= 1'b1;
            pc_q              <= pc_q + 64'd8;
          end
        end

        S_HALT: begin
          if (fc.start) begin
            state_q     <= S_LOAD;
            pc_q        <= RESET_PC;
            cnt_q       <= CNT_W'(LOAD_WAIT);
            mem_load_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
          end else if (fc.redirect_valid) begin
            out_valid_q <= 1'b0;
            if (redir_in_range) begin
              state_q  <= S_RUN;
              pc_q     <= redir_pc;
              busy_q   <= 1'b1;
              halted_q <= 1'b0;
            end
          end else if (fc.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign fc.mem_load        = mem_load_q;
  assign fc.mem_addr        = pc_q;
  assign fc.out_valid       = out_valid_q;
  assign fc.out_instruction = out_instruction_q;
  assign fc.out_pc          = out_pc_q;
  assign fc.busy            = busy_q;
  assign fc.halted          = halted_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed and randomized bench for instruction_fetch_controller; a transaction-level
// scoreboard predicts the accepted PC/instruction stream from redirects and PC+8 stepping.
module tb_instruction_fetch_controller;

  localparam int unsigned NUM  = 15;
  localparam int unsigned WAIT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [63:0] mem [0:NUM-1];

  instruction_fetch_controller_if ifc ();

  instruction_fetch_controller #(
    .NUM_INSTRUCTIONS (NUM),
    .LOAD_WAIT        (WAIT),
    .RESET_PC         (64'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (ifc)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] addr);
    if ((addr >> 3) < 64'(NUM)) return mem[int'(addr >> 3)];
    return 64'h0;
  endfunction

  assign ifc.mem_instruction = mem_word(ifc.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Walks the LOAD window that follows the start edge; optionally pokes ignored inputs.
  task automatic load_phase(input bit inject);
    for (int k = 0; k < int'(WAIT); k++) begin
      chk("load_busy", 64'(ifc.busy), 64'd1);
      chk("load_strobe", 64'(ifc.mem_load), (k == 0) ? 64'd1 : 64'd0);
      chk("load_valid", 64'(ifc.out_valid), 64'd0);
      if (inject && k == 1) begin
        ifc.start           = 1'b1;
        ifc.redirect_valid  = 1'b1;
        ifc.redirect_target = 64'h10;
      end else begin
        ifc.start          = 1'b0;
        ifc.redirect_valid = 1'b0;
      end
      step();
    end
    chk("run_entry_busy", 64'(ifc.busy), 64'd1);
    chk("run_entry_valid", 64'(ifc.out_valid), 64'd0);
    chk("run_entry_addr", ifc.mem_addr, 64'd0);
  endtask

  task automatic start_pulse();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_pc, held_pc, held_ins, tgt;
    logic        held, rdy, rv;

    checks = 0;
    errors = 0;
    for (int i = 0; i < int'(NUM); i++) mem[i] = {$urandom, $urandom};

    rst_n               = 1'b0;
    ifc.start           = 1'b0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_target = 64'd0;
    ifc.out_ready       = 1'b1;
    #1;
    chk("rst_mem_load", 64'(ifc.mem_load), 64'd0);
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_ins", ifc.out_instruction, 64'd0);
    chk("rst_pc", ifc.out_pc, 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_halted", 64'(ifc.halted), 64'd0);
    chk("rst_addr", ifc.mem_addr, 64'd0);
    #11 rst_n = 1'b1;
    step();

    // Full program stream at one word per cycle.
    start_pulse();
    load_phase(1'b0);
    for (int i = 0; i < int'(NUM); i++) begin
      step();
      chk("stream_valid", 64'(ifc.out_valid), 64'd1);
      chk("stream_pc", ifc.out_pc, 64'(i * 8));
      chk("stream_ins", ifc.out_instruction, mem[i]);
    end
    step();
    chk("end_halted", 64'(ifc.halted), 64'd1);
    chk("end_busy", 64'(ifc.busy), 64'd0);
    chk("end_valid", 64'(ifc.out_valid), 64'd0);

    // Backpressure holds the slot and the PC.
    start_pulse();
    load_phase(1'b0);
    step();
    chk("bp_pc0", ifc.out_pc, 64'd0);
    step();
    chk("bp_pc8", ifc.out_pc, 64'd8);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 64'(ifc.out_valid), 64'd1);
      chk("bp_hold_pc", ifc.out_pc, 64'd8);
      chk("bp_hold_ins", ifc.out_instruction, mem[1]);
      chk("bp_hold_addr", ifc.mem_addr, 64'd16);
    end
    ifc.out_ready = 1'b1;
    step();
    chk("bp_release_pc", ifc.out_pc, 64'd16);

    // In-range redirect flushes the slot and aligns the target.
    ifc.redirect_valid  = 1'b1;
    ifc.redirect_target = 64'h29;
    step();
    ifc.redirect_valid = 1'b0;
    chk("redir_flush", 64'(ifc.out_valid), 64'd0);
    chk("redir_addr", ifc.mem_addr, 64'h28);
    step();
    chk("redir_pc", ifc.out_pc, 64'h28);
    chk("redir_ins", ifc.out_instruction, mem[5]);

    // Out-of-range redirect halts; an in-range one resumes.
    ifc.redirect_valid  = 1'b1;
    ifc.redirect_target = 64'h100;
    step();
    ifc.redirect_valid = 1'b0;
    chk("oor_valid", 64'(ifc.out_valid), 64'd0);
    chk("oor_halted", 64'(ifc.halted), 64'd1);
    step();
    chk("oor_stay", 64'(ifc.halted), 64'd1);
    ifc.redirect_valid  = 1'b1;
    ifc.redirect_target = 64'h10;
    step();
    ifc.redirect_valid = 1'b0;
    chk("resume_halted", 64'(ifc.halted), 64'd0);
    chk("resume_busy", 64'(ifc.busy), 64'd1);
    chk("resume_addr", ifc.mem_addr, 64'h10);
    step();
    chk("resume_pc", ifc.out_pc, 64'h10);
    chk("resume_ins", ifc.out_instruction, mem[2]);

    // start/redirect during LOAD are ignored.
    ifc.redirect_valid  = 1'b1;
    ifc.redirect_target = 64'h100;
    step();
    ifc.redirect_valid = 1'b0;
    start_pulse();
    load_phase(1'b1);
    step();
    chk("ign_pc", ifc.out_pc, 64'd0);

    // Asynchronous reset mid-RUN with a held output.
    chk("pre_rst_valid", 64'(ifc.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ifc.out_valid), 64'd0);
    chk("arst_addr", ifc.mem_addr, 64'd0);
    chk("arst_busy", 64'(ifc.busy), 64'd0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 64'(ifc.busy), 64'd0);
    start_pulse();
    load_phase(1'b0);
    step();
    chk("restart_pc", ifc.out_pc, 64'd0);
    chk("restart_ins", ifc.out_instruction, mem[0]);

    // Random backpressure and redirects against the stream scoreboard.
    exp_pc = 64'd8;
    held   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (held) begin
        chk("rnd_hold_valid", 64'(ifc.out_valid), 64'd1);
        chk("rnd_hold_pc", ifc.out_pc, held_pc);
        chk("rnd_hold_ins", ifc.out_instruction, held_ins);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      tgt = 64'($urandom_range(0, NUM * 8 + 24));
      ifc.out_ready       = rdy;
      ifc.redirect_valid  = rv;
      ifc.redirect_target = tgt;
      if (ifc.out_valid && rdy && !rv) begin
        chk("rnd_pc", ifc.out_pc, exp_pc - 64'd8);
        chk("rnd_in_range", 64'((ifc.out_pc >> 3) < 64'(NUM)), 64'd1);
        chk("rnd_ins", ifc.out_instruction, mem_word(ifc.out_pc));
        exp_pc = exp_pc + 64'd8;
      end
      held     = ifc.out_valid && !rdy && !rv;
      held_pc  = ifc.out_pc;
      held_ins = ifc.out_instruction;
      if (rv) exp_pc = (tgt & ~64'h7) + 64'd8;
      step();
    end

    ifc.redirect_valid = 1'b0;
    ifc.out_ready      = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("drain_halted", 64'(ifc.halted), 64'd1);
    chk("drain_valid", 64'(ifc.out_valid), 64'd0);
    chk("drain_busy", 64'(ifc.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
